// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU control codes, MIPS opcode/funct values and the issue-buffer occupancy states.
package alu_issue_stage_pkg;

  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } count_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct/immediate decode into ALU control, operand-A select and operand B.
module alu_op_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rt_val,
  input  logic [15:0]       imm,
  output logic [4:0]        ctrl,
  output logic              a_sel,
  output logic [DATA_W-1:0] b_val,
  output logic              illegal
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    ctrl    = ALU_ADD;
    a_sel   = 1'b1;
    b_val   = rt_val;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: ctrl = ALU_ADD;
          FUNCT_SUB, FUNCT_SUBU: ctrl = ALU_SUB;
          FUNCT_AND:             ctrl = ALU_AND;
          FUNCT_OR:              ctrl = ALU_OR;
          default:               illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: b_val = imm_sext;
      OP_ANDI: begin
        ctrl  = ALU_AND;
        b_val = imm_zext;
      end
      OP_ORI: begin
        ctrl  = ALU_OR;
        b_val = imm_zext;
      end
      OP_BEQ, OP_BNE: ctrl = ALU_SUB;
      default:        illegal = 1'b1;
    endcase
    // Unsupported ops become a harmless 0+0 so EX never sees a stray code.
    if (illegal) begin
      ctrl  = ALU_ADD;
      a_sel = 1'b0;
      b_val = '0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ID ops at accept time and holds up to two in a skid buffer toward EX.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src_a,
  output logic [DATA_W-1:0] src_b,
  output logic [4:0]        sig_alu_control,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_illegal
);

  typedef struct packed {
    logic [4:0]        ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DEST_W-1:0] dest;
    logic              illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = {ALU_ADD, {(2*DATA_W+DEST_W+1){1'b0}}};

  count_state_e count_reg, count_next;
  logic         in_ready_reg;
  logic         out_valid_reg;
  entry_t       slot_reg  [2];
  entry_t       slot_next [2];
  logic [1:0]   slot_we;
  entry_t       new_entry;

  logic              dec_a_sel;
  logic              dec_illegal;
  logic [4:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_b;
  logic              push;
  logic              pop;

  alu_op_decode #(.DATA_W(DATA_W)) u_decode (
    .opcode  (in_opcode),
    .funct   (in_funct),
    .rt_val  (in_rt_val),
    .imm     (in_imm),
    .ctrl    (dec_ctrl),
    .a_sel   (dec_a_sel),
    .b_val   (dec_b),
    .illegal (dec_illegal)
  );

  assign push = in_valid & in_ready_reg;
  assign pop  = out_valid_reg & out_ready;

  always_comb begin
    new_entry.ctrl    = dec_ctrl;
    new_entry.a       = dec_a_sel ? in_rs_val : '0;
    new_entry.b       = dec_b;
    new_entry.dest    = in_dest;
    new_entry.illegal = dec_illegal;
  end

  // Slot 0 is the head driven to EX; slot 1 is the skid entry.
  always_comb begin
    count_next   = count_reg;
    slot_we      = 2'b00;
    slot_next[0] = new_entry;
    slot_next[1] = new_entry;
    if (flush) begin
      count_next = ST_EMPTY;
    end else begin
      case (count_reg)
        ST_EMPTY: begin
          if (push) begin
            count_next = ST_ONE;
            slot_we[0] = 1'b1;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            slot_we[0] = 1'b1;
          end else if (push) begin
            count_next = ST_FULL;
            slot_we[1] = 1'b1;
          end else if (pop) begin
            count_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            count_next   = ST_ONE;
            slot_we[0]   = 1'b1;
            slot_next[0] = slot_reg[1];
          end
        end
        default: count_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 2; i++) slot_reg[i] <= RESET_ENTRY;
    end else begin
      count_reg     <= count_next;
      in_ready_reg  <= (count_next != ST_FULL);
      out_valid_reg <= (count_next != ST_EMPTY);
      for (int i = 0; i < 2; i++) begin
        if (slot_we[i]) slot_reg[i] <= slot_next[i];
      end
    end
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_reg == ST_FULL)));

  assign in_ready        = in_ready_reg;
  assign out_valid       = out_valid_reg;
  assign src_a           = slot_reg[0].a;
  assign src_b           = slot_reg[0].b;
  assign sig_alu_control = slot_reg[0].ctrl;
  assign out_dest        = slot_reg[0].dest;
  assign out_illegal     = slot_reg[0].illegal;

endmodule
